ifid_skid_stage: RTL and testbench
==================================

# ifid_skid_stage

Parametrised IF→ID pipeline register with a skid buffer, flush and multi-lane fetch bundles. It sits between the fetch stage and decode. Instructions already in flight from IF when decode stalls are captured in an internal FIFO rather than dropped. A branch-redirect flush discards all held state in one cycle.

## Interface
- `LANES`, 1 — instructions per fetch bundle (1, 2 or 4)
- `DATA_W`, 32 — instruction width
- `ADDR_W`, 32 — PC width
- `SKID_DEPTH`, 2 — skid FIFO entries (power of two, ≥1)
- `CNT_W`, 16 — stall counter width
- `CLK`  in  1  sole clock, rising edge
- `RESET`  in  1  synchronous, active-high reset
- `FLUSH`  in  1  discard all held and incoming bundles (redirect)
- `STALL`  in  1  decode cannot accept; hold output
- `in_valid`  in  1  IF presents a bundle
- `in_ready`  out  1  stage can accept; combinational, = (skid count < SKID_DEPTH)
- `Instr_IF`  in  LANES*DATA_W  bundle; lane i at bits [i*DATA_W +: DATA_W]
- `Instr_lane_valid_IF`  in  LANES  per-lane valid mask
- `Instr_PC_IF`  in  ADDR_W  PC of lane 0
- `Instr_PC_Plus4_IF`  in  ADDR_W  next-fetch PC
- `out_valid`  out  1  output bundle valid
- `Instr_OUT`  out  LANES*DATA_W  registered bundle
- `Instr_lane_valid_OUT`  out  LANES  registered lane mask
- `Instr_PC_OUT`  out  ADDR_W  registered PC
- `Instr_PC_Plus4`  out  ADDR_W  registered next PC
- `skid_count`  out  $clog2(SKID_DEPTH+1)  current skid occupancy
- `stall_cycles`  out  CNT_W  saturating count of cycles with STALL & out_valid

## Operation
- Accept when in_valid & in_ready. A bundle whose lane mask is all zero is accepted and discarded.
- Per-cycle priority: RESET > FLUSH > normal.
- FLUSH: out_valid←0, skid emptied, and any bundle accepted that cycle dropped. Output data fields hold. stall_cycles is unaffected.
- Normal, STALL=1:
  - Output registers are held.
  - An accepted bundle is pushed to the skid FIFO.
- Normal, STALL=0:
  - Skid non-empty: output←skid head (pop). An accepted bundle is pushed in the same cycle; order is preserved.
  - Skid empty and bundle accepted: output←input directly (bypass).
  - Otherwise: out_valid←0; data fields hold.
- Ordering is strict FIFO; bundles are never reordered or duplicated.
- stall_cycles increments when STALL & out_valid & !FLUSH and saturates at all-ones. It clears only on RESET.

## Timing
- Reset values: out_valid=0, Instr_OUT=0, Instr_lane_valid_OUT=0, Instr_PC_OUT=0, Instr_PC_Plus4=0, skid_count=0, stall_cycles=0, FIFO pointers=0. in_ready=1 after reset.
- Latency with the skid empty and no stall: 1 cycle, input at edge N visible at outputs after edge N.
- Bundles that entered the skid leave in FIFO order, one per non-stalled cycle.
- Full boundary: with skid_count==SKID_DEPTH, in_ready=0 in the same cycle. A non-stalled pop raises in_ready in the following cycle, since in_ready depends only on registered count.
- Wrap-around: FIFO pointers are modulo SKID_DEPTH and carry no extra bit; count tracks fullness.
- Simultaneous STALL & FLUSH: flush wins, and out_valid is 0 the next cycle.
- RESET asserted mid-stall drops all content in one cycle.

## Configuration
- `IFID_TRACE_EN` defined: each output load prints PC, bundle, next PC and source (bypass or skid) via `$display`. Each stalled accept prints a "stalling" line with PC and skid_count. Each flush prints the dropped count.
- Not defined: no simulation output. Synthesised logic is identical either way.

## Structure
- Shared package `ifid_pkg`:
  - typedef `ifid_bundle_t` {instr[LANES*DATA_W], lane_valid[LANES], pc[ADDR_W], pc_plus4[ADDR_W]}
  - default widths
  - `IFID_RESET_BUNDLE` constant (all zero)
- One sub-module, `ifid_skid_fifo`: SKID_DEPTH-entry synchronous FIFO with push, pop, flush and count. The top level holds the output register, the bypass mux and the stall counter.

## Test plan
- Stream with no stall: PCs 0x100, 0x104, 0x108 on consecutive cycles → Instr_PC_OUT shows each one cycle later; skid_count stays 0.
- STALL for 3 cycles, SKID_DEPTH=2, in_valid held: two bundles (0x200, 0x204) are captured and in_ready drops at count 2. After release, the outputs present 0x200 then 0x204 on consecutive cycles with no loss.
- FLUSH while skid_count=2 and in_valid=1 → next cycle out_valid=0, skid_count=0; the flushed PCs never appear.
- STALL & FLUSH in the same cycle → flush behaviour; stall_cycles does not increment that cycle.
- CNT_W=4, STALL held 20 cycles with out_valid=1 → stall_cycles saturates at 15.
- LANES=2, lane mask 2'b01 with PC 0x300 → Instr_lane_valid_OUT=2'b01 and the lane-1 field is passed unaltered. An all-zero mask input never produces out_valid.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared IF->ID pipeline types: default widths, bundle struct, reset constant.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: IFID_* default widths, ifid_bundle_t, IFID_RESET_BUNDLE, ifid_ptr_w().
package ifid_pkg;

  localparam int IFID_LANES      = 1;
  localparam int IFID_DATA_W     = 32;
  localparam int IFID_ADDR_W     = 32;
  localparam int IFID_SKID_DEPTH = 2;
  localparam int IFID_CNT_W      = 16;

  // Bundle at default widths; parametrised modules build the same layout locally.
  typedef struct packed {
    logic [IFID_LANES*IFID_DATA_W-1:0] instr;
    logic [IFID_LANES-1:0]             lane_valid;
    logic [IFID_ADDR_W-1:0]            pc;
    logic [IFID_ADDR_W-1:0]            pc_plus4;
  } ifid_bundle_t;

  localparam ifid_bundle_t IFID_RESET_BUNDLE = '0;

  // Pointer width for a modulo-depth FIFO; a single-entry FIFO still needs one bit.
  function automatic int ifid_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifid_skid_fifo.sv
// Skid FIFO holding fetch bundles that arrive while decode is stalled.
// Latency: push visible at head the cycle after; head is read combinationally.
// Backpressure: none internally; caller must not push when full or pop when empty.
// Ports: clk, reset (sync, high), push, pop, flush, din, dout (head), count.
module ifid_skid_fifo
  import ifid_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = ifid_ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap at DEPTH with no extra lap bit; count alone tells full from empty.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ifid_skid_stage.sv
// IF->ID pipeline register with skid FIFO, redirect flush and stall counter.
// Latency: 1 cycle when the skid is empty and decode is not stalled.
// Backpressure: in_ready = skid not full; in-flight bundles during STALL go to the skid.
// Ports: CLK, RESET (sync, high), FLUSH, STALL, in_valid/in_ready, Instr_*_IF in,
//        out_valid, Instr_*_OUT / Instr_PC_Plus4 out, skid_count, stall_cycles.
// Optional: define IFID_TRACE_EN for simulation trace prints (no logic change).
module ifid_skid_stage
  import ifid_pkg::*;
#(
  parameter int LANES      = IFID_LANES,
  parameter int DATA_W     = IFID_DATA_W,
  parameter int ADDR_W     = IFID_ADDR_W,
  parameter int SKID_DEPTH = IFID_SKID_DEPTH,
  parameter int CNT_W      = IFID_CNT_W,
  localparam int SCW       = $clog2(SKID_DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    FLUSH,
  input  logic                    STALL,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] Instr_IF,
  input  logic [LANES-1:0]        Instr_lane_valid_IF,
  input  logic [ADDR_W-1:0]       Instr_PC_IF,
  input  logic [ADDR_W-1:0]       Instr_PC_Plus4_IF,
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] Instr_OUT,
  output logic [LANES-1:0]        Instr_lane_valid_OUT,
  output logic [ADDR_W-1:0]       Instr_PC_OUT,
  output logic [ADDR_W-1:0]       Instr_PC_Plus4,
  output logic [SCW-1:0]          skid_count,
  output logic [CNT_W-1:0]        stall_cycles
);

  typedef struct packed {
    logic [LANES*DATA_W-1:0] instr;
    logic [LANES-1:0]        lane_valid;
    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       pc_plus4;
  } bundle_t;

  bundle_t in_b;
  bundle_t head_b;
  bundle_t out_b;
  logic    accept;
  logic    keep;
  logic    skid_empty;
  logic    push;
  logic    pop;

  assign in_b = '{instr: Instr_IF, lane_valid: Instr_lane_valid_IF,
                  pc: Instr_PC_IF, pc_plus4: Instr_PC_Plus4_IF};

  // Depends only on the registered count, so no path from STALL/FLUSH to in_ready.
  assign in_ready   = (skid_count < SCW'(SKID_DEPTH));
  assign accept     = in_valid & in_ready;
  // An empty lane mask is consumed but carries nothing, so it is never stored.
  assign keep       = accept & (|Instr_lane_valid_IF);
  assign skid_empty = (skid_count == '0);
  // Bypass only when nothing older is queued; otherwise queue behind the head.
  assign push       = !FLUSH & keep & (STALL | !skid_empty);
  assign pop        = !FLUSH & !STALL & !skid_empty;

  ifid_skid_fifo #(
    .W     ($bits(bundle_t)),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk   (CLK),
    .reset (RESET),
    .push  (push),
    .pop   (pop),
    .flush (FLUSH),
    .din   (in_b),
    .dout  (head_b),
    .count (skid_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid    <= 1'b0;
      out_b        <= '0;
      stall_cycles <= '0;
    end else if (FLUSH) begin
      out_valid <= 1'b0;
    end else begin
      if (STALL && out_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (!STALL) begin
        if (!skid_empty) begin
          out_b     <= head_b;
          out_valid <= 1'b1;
        end else if (keep) begin
          out_b     <= in_b;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign Instr_OUT            = out_b.instr;
  assign Instr_lane_valid_OUT = out_b.lane_valid;
  assign Instr_PC_OUT         = out_b.pc;
  assign Instr_PC_Plus4       = out_b.pc_plus4;

`ifdef IFID_TRACE_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (FLUSH) begin
        $display("ifid: flush dropped %0d", int'(skid_count) + int'(keep));
      end else begin
        if (!STALL && !skid_empty)
          $display("ifid: load pc=%h bundle=%h next=%h src=skid",
                   head_b.pc, head_b.instr, head_b.pc_plus4);
        else if (!STALL && keep)
          $display("ifid: load pc=%h bundle=%h next=%h src=bypass",
                   in_b.pc, in_b.instr, in_b.pc_plus4);
        if (STALL && keep)
          $display("ifid: stalling pc=%h skid_count=%0d", in_b.pc, skid_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage (LANES=2, SKID_DEPTH=2, CNT_W=4).
// Latency: reference model updated once per rising edge, outputs sampled 1ns later.
// Backpressure: model honours in_ready from its own queue occupancy.
module tb_ifid_skid_stage;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic                    CLK = 1'b0;
  logic                    RESET, FLUSH, STALL, in_valid, in_ready, out_valid;
  logic [LANES*DATA_W-1:0] Instr_IF, Instr_OUT;
  logic [LANES-1:0]        Instr_lane_valid_IF, Instr_lane_valid_OUT;
  logic [ADDR_W-1:0]       Instr_PC_IF, Instr_PC_Plus4_IF, Instr_PC_OUT, Instr_PC_Plus4;
  logic [1:0]              skid_count;
  logic [CNT_W-1:0]        stall_cycles;

  always #5 CLK = ~CLK;

  ifid_skid_stage #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKID_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .STALL(STALL),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr_IF(Instr_IF), .Instr_lane_valid_IF(Instr_lane_valid_IF),
    .Instr_PC_IF(Instr_PC_IF), .Instr_PC_Plus4_IF(Instr_PC_Plus4_IF),
    .out_valid(out_valid), .Instr_OUT(Instr_OUT), .Instr_lane_valid_OUT(Instr_lane_valid_OUT),
    .Instr_PC_OUT(Instr_PC_OUT), .Instr_PC_Plus4(Instr_PC_Plus4),
    .skid_count(skid_count), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [LANES*DATA_W-1:0] instr;
    logic [LANES-1:0]        lv;
    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       pc4;
  } bun_t;

  // Reference: a queue of held bundles plus the visible output bundle.
  bun_t q[$];
  bun_t m_out;
  bit   m_vld;
  int   m_stall;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit fl, input bit st, input bit v, input bun_t b);
    bit acc;
    bit useful;
    acc    = v && (q.size() < DEPTH);
    useful = acc && (b.lv != '0);
    if (rst) begin
      q.delete(); m_vld = 0; m_out = '0; m_stall = 0;
    end else if (fl) begin
      q.delete(); m_vld = 0;
    end else begin
      if (st && m_vld && m_stall < SAT) m_stall++;
      if (st) begin
        if (useful) q.push_back(b);
      end else if (q.size() > 0) begin
        m_out = q.pop_front(); m_vld = 1;
        if (useful) q.push_back(b);
      end else if (useful) begin
        m_out = b; m_vld = 1;
      end else begin
        m_vld = 0;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit fl, input bit st, input bit v,
                     input logic [31:0] pc, input logic [1:0] lv);
    bun_t b;
    b.instr = {$urandom, $urandom};
    b.lv    = lv;
    b.pc    = pc;
    b.pc4   = pc + 32'd8;
    RESET = rst; FLUSH = fl; STALL = st; in_valid = v;
    Instr_IF = b.instr; Instr_lane_valid_IF = b.lv;
    Instr_PC_IF = b.pc; Instr_PC_Plus4_IF = b.pc4;
    #1;
    chk("in_ready", in_ready, (q.size() < DEPTH));
    @(posedge CLK);
    model_edge(rst, fl, st, v, b);
    #1;
    chk("out_valid", out_valid, m_vld);
    chk("skid_count", skid_count, q.size());
    chk("stall_cycles", stall_cycles, m_stall);
    chk("bundle", {Instr_OUT, Instr_lane_valid_OUT, Instr_PC_OUT, Instr_PC_Plus4}, m_out);
  endtask

  initial begin
    m_out = '0; m_vld = 0; m_stall = 0;
    RESET = 1; FLUSH = 0; STALL = 0; in_valid = 0;
    Instr_IF = '0; Instr_lane_valid_IF = '0; Instr_PC_IF = '0; Instr_PC_Plus4_IF = '0;
    @(posedge CLK); #1;

    // Reset state.
    cyc(1, 0, 0, 1, 32'h0dead, 2'b11);
    chk("reset_in_ready", in_ready, 1'b1);

    // Unstalled stream: one-cycle latency, skid stays empty.
    cyc(0, 0, 0, 1, 32'h100, 2'b11);
    chk("stream_pc0", Instr_PC_OUT, 32'h100);
    cyc(0, 0, 0, 1, 32'h104, 2'b11);
    cyc(0, 0, 0, 1, 32'h108, 2'b11);
    chk("stream_pc2", Instr_PC_OUT, 32'h108);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);

    // Stall with in_valid held: two captured, third refused, drained in order.
    cyc(0, 0, 0, 1, 32'h1f0, 2'b11);
    cyc(0, 0, 1, 1, 32'h200, 2'b11);
    cyc(0, 0, 1, 1, 32'h204, 2'b11);
    cyc(0, 0, 1, 1, 32'h208, 2'b11);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);
    chk("drain_first", Instr_PC_OUT, 32'h200);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);
    chk("drain_second", Instr_PC_OUT, 32'h204);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);

    // Flush with a full skid and a bundle offered.
    cyc(0, 0, 1, 1, 32'h400, 2'b11);
    cyc(0, 0, 1, 1, 32'h404, 2'b11);
    cyc(0, 1, 0, 1, 32'h408, 2'b11);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);

    // Stall and flush together.
    cyc(0, 0, 0, 1, 32'h500, 2'b11);
    cyc(0, 1, 1, 1, 32'h504, 2'b11);
    cyc(0, 0, 1, 0, 32'h0, 2'b00);

    // Stall counter saturation.
    cyc(1, 0, 0, 0, 32'h0, 2'b00);
    cyc(0, 0, 0, 1, 32'h600, 2'b11);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 32'h0, 2'b00);
    chk("stall_saturated", stall_cycles, SAT);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);

    // Partial lane mask, then all-zero masks.
    cyc(0, 0, 0, 1, 32'h300, 2'b01);
    chk("lane_mask", Instr_lane_valid_OUT, 2'b01);
    cyc(0, 0, 0, 1, 32'h308, 2'b00);
    cyc(0, 0, 0, 1, 32'h310, 2'b00);
    chk("zero_mask_no_valid", out_valid, 1'b0);

    // Reset in the middle of a stall.
    cyc(0, 0, 0, 1, 32'h700, 2'b11);
    cyc(0, 0, 1, 1, 32'h704, 2'b10);
    cyc(0, 0, 1, 1, 32'h708, 2'b01);
    cyc(1, 0, 1, 1, 32'h70c, 2'b11);
    cyc(0, 0, 0, 0, 32'h0, 2'b00);

    // Randomised traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 75, $urandom & 32'hffff_fffc, 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
